// File: rtl/pipeline_ctrl_task3_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
interface pipeline_ctrl_task3_if;
    logic [4:0] ifid_rs1;
    logic [4:0] ifid_rs2;
    logic       idex_memread;
    logic [4:0] idex_rd;
    logic       exmem_branch;
    logic       exmem_zero;
    logic       exmem_is_greater;
    logic [3:0] exmem_func;
    logic       exmem_memread;
    logic       exmem_memwrite;
    logic       mem_ready;

    logic        pc_write;
    logic        ifid_write;
    logic        pc_src;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic        hold_all;
    logic        mem_error;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    // Datapath side: presents pipeline fields, consumes control
    modport master (
        output ifid_rs1, ifid_rs2, idex_memread, idex_rd,
               exmem_branch, exmem_zero, exmem_is_greater, exmem_func,
               exmem_memread, exmem_memwrite, mem_ready,
        input  pc_write, ifid_write, pc_src, ifid_flush, idex_flush,
               exmem_flush, hold_all, mem_error, stall_count, flush_count
    );

    // Controller side
    modport slave (
        input  ifid_rs1, ifid_rs2, idex_memread, idex_rd,
               exmem_branch, exmem_zero, exmem_is_greater, exmem_func,
               exmem_memread, exmem_memwrite, mem_ready,
        output pc_write, ifid_write, pc_src, ifid_flush, idex_flush,
               exmem_flush, hold_all, mem_error, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_ctrl_task3.sv
// Hazard/sequencing controller: memory-wait freeze with timeout, branch
// flush, load-use bubble, and saturating stall/flush counters.
module pipeline_ctrl_task3 #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_ctrl_task3_if.slave bus
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned PC_W  = 16;
    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    logic [0:0]      state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_nxt;
    logic             mem_error, err_nxt;
    logic [PC_W-1:0]  stall_count, stall_nxt;
    logic [PC_W-1:0]  flush_count, flush_nxt;

    logic hold, taken, cond, lu, mem_acc;
    logic pc_write, ifid_write, pc_src, ifid_flush, idex_flush, exmem_flush;
    logic unused_func;

    // Funct7 bit is carried in the bus but does not affect branch decode
    assign unused_func = bus.exmem_func[3];

    // Branch condition decode and load-use detection
    always_comb begin
        mem_acc = bus.exmem_memread | bus.exmem_memwrite;
        case (bus.exmem_func[2:0])
            3'b000:  cond = bus.exmem_zero;
            3'b001:  cond = !bus.exmem_zero;
            3'b100:  cond = !bus.exmem_zero & !bus.exmem_is_greater;
            3'b101:  cond = bus.exmem_zero | bus.exmem_is_greater;
            default: cond = 1'b0;
        endcase
        taken = bus.exmem_branch & cond;
        lu    = bus.idex_memread & (bus.idex_rd != 5'd0) &
                ((bus.idex_rd == bus.ifid_rs1) | (bus.idex_rd == bus.ifid_rs2));
    end

    // Next-state, hold decision, prioritised control outputs and counters
    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        err_nxt     = mem_error;
        hold        = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        pc_src      = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        stall_nxt   = stall_count;
        flush_nxt   = flush_count;

        case (state)
            RUN: begin
                if (mem_acc && !bus.mem_ready) begin
                    hold      = 1'b1;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                    err_nxt   = 1'b1;
                end else begin
                    hold     = 1'b1;
                    wait_nxt = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase

        // Reset forces the idle control pattern and drops any hold at once
        if (reset) begin
            hold = 1'b0;
        end else if (hold) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (taken) begin
            pc_src      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            if (flush_count != '1) flush_nxt = flush_count + PC_W'(1);
        end else if (lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            if (stall_count != '1) stall_nxt = stall_count + PC_W'(1);
        end
    end

    // State, wait counter, sticky error and performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_error   <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            mem_error   <= err_nxt;
            stall_count <= stall_nxt;
            flush_count <= flush_nxt;
        end
    end

    assign bus.pc_write    = pc_write;
    assign bus.ifid_write  = ifid_write;
    assign bus.pc_src      = pc_src;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_flush = exmem_flush;
    assign bus.hold_all    = hold;
    assign bus.mem_error   = mem_error;
    assign bus.stall_count = stall_count;
    assign bus.flush_count = flush_count;
endmodule

// File: tb/tb_pipeline_ctrl_task3.sv
// Directed bench for the pipeline hazard controller (MEM_TIMEOUT = 4).
module tb_pipeline_ctrl_task3;
    logic clk;
    logic reset;
    int   tests;
    int   fails;
    logic [15:0] exp_stall;
    logic [15:0] exp_flush;

    // Control vector: {pc_write, ifid_write, pc_src, ifid_flush, idex_flush, exmem_flush, hold_all}
    localparam logic [6:0] C_IDLE  = 7'b1100000;
    localparam logic [6:0] C_STALL = 7'b0000100;
    localparam logic [6:0] C_TAKEN = 7'b1111110;
    localparam logic [6:0] C_HOLD  = 7'b0000001;

    pipeline_ctrl_task3_if bus();

    pipeline_ctrl_task3 #(.MEM_TIMEOUT(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ctl();
        return {bus.pc_write, bus.ifid_write, bus.pc_src, bus.ifid_flush,
                bus.idex_flush, bus.exmem_flush, bus.hold_all};
    endfunction

    task automatic clear_inputs();
        bus.ifid_rs1 = 5'd0; bus.ifid_rs2 = 5'd0;
        bus.idex_memread = 1'b0; bus.idex_rd = 5'd0;
        bus.exmem_branch = 1'b0; bus.exmem_zero = 1'b0;
        bus.exmem_is_greater = 1'b0; bus.exmem_func = 4'd0;
        bus.exmem_memread = 1'b0; bus.exmem_memwrite = 1'b0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic set_branch(input logic [3:0] func, input logic zero, input logic gt);
        clear_inputs();
        bus.exmem_branch = 1'b1; bus.exmem_func = func;
        bus.exmem_zero = zero; bus.exmem_is_greater = gt;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        bus.idex_memread = 1'b1; bus.idex_rd = rd;
        bus.ifid_rs1 = rs1; bus.ifid_rs2 = rs2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        set_lu(5'd7, 5'd7, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (ctl() !== C_IDLE) begin fails++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), C_IDLE); end
        tests++;
        if ({bus.mem_error, bus.stall_count, bus.flush_count} !== 33'd0) begin
            fails++; $display("FAIL reset_regs got err=%b st=%0d fl=%0d exp 0/0/0",
                              bus.mem_error, bus.stall_count, bus.flush_count);
        end
        clear_inputs();
        reset = 1'b0;
        @(posedge clk); #1;
        exp_stall = 16'd0; exp_flush = 16'd0;
    endtask

    task automatic test_load_use();
        clear_inputs(); set_lu(5'd5, 5'd1, 5'd5);
        @(negedge clk);
        tests++;
        if (ctl() !== C_STALL) begin fails++; $display("FAIL lu_ctl got=%b exp=%b", ctl(), C_STALL); end
        @(posedge clk); #1;
        exp_stall++;
        tests++;
        if (bus.stall_count !== exp_stall) begin fails++; $display("FAIL lu_count got=%0d exp=%0d", bus.stall_count, exp_stall); end
        // Load to x0 never hazards
        clear_inputs(); set_lu(5'd0, 5'd0, 5'd0);
        @(negedge clk);
        tests++;
        if (ctl() !== C_IDLE) begin fails++; $display("FAIL lu_x0_ctl got=%b exp=%b", ctl(), C_IDLE); end
        @(posedge clk); #1;
        tests++;
        if (bus.stall_count !== exp_stall) begin fails++; $display("FAIL lu_x0_count got=%0d exp=%0d", bus.stall_count, exp_stall); end
        // Load without a matching source register
        clear_inputs(); set_lu(5'd9, 5'd8, 5'd10);
        @(negedge clk);
        tests++;
        if (ctl() !== C_IDLE) begin fails++; $display("FAIL lu_nomatch_ctl got=%b exp=%b", ctl(), C_IDLE); end
        @(posedge clk); #1;
    endtask

    task automatic test_branches();
        logic [3:0] fn  [8] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b1101, 4'b0100, 4'b0100, 4'b0010};
        logic       zr  [8] = '{1'b0,    1'b1,    1'b1,    1'b0,    1'b0,    1'b0,    1'b0,    1'b1};
        logic       gt  [8] = '{1'b0,    1'b0,    1'b0,    1'b0,    1'b1,    1'b1,    1'b0,    1'b0};
        logic       tk  [8] = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0};
        for (int i = 0; i < 8; i++) begin
            set_branch(fn[i], zr[i], gt[i]);
            @(negedge clk);
            tests++;
            if (ctl() !== (tk[i] ? C_TAKEN : C_IDLE)) begin
                fails++; $display("FAIL branch_ctl[%0d] got=%b exp=%b", i, ctl(), tk[i] ? C_TAKEN : C_IDLE);
            end
            @(posedge clk); #1;
            if (tk[i]) exp_flush++;
            tests++;
            if (bus.flush_count !== exp_flush) begin
                fails++; $display("FAIL branch_count[%0d] got=%0d exp=%0d", i, bus.flush_count, exp_flush);
            end
        end
        // Condition true but not a branch
        set_branch(4'b0000, 1'b1, 1'b0); bus.exmem_branch = 1'b0;
        @(negedge clk);
        tests++;
        if (ctl() !== C_IDLE) begin fails++; $display("FAIL nobranch_ctl got=%b exp=%b", ctl(), C_IDLE); end
        @(posedge clk); #1;
    endtask

    task automatic test_priority();
        // Taken branch overrides load-use; only flush counter moves
        set_branch(4'b0000, 1'b1, 1'b0); set_lu(5'd3, 5'd3, 5'd0);
        @(negedge clk);
        tests++;
        if (ctl() !== C_TAKEN) begin fails++; $display("FAIL prio_ctl got=%b exp=%b", ctl(), C_TAKEN); end
        @(posedge clk); #1;
        exp_flush++;
        tests++;
        if ({bus.stall_count, bus.flush_count} !== {exp_stall, exp_flush}) begin
            fails++; $display("FAIL prio_count got st=%0d fl=%0d exp st=%0d fl=%0d",
                              bus.stall_count, bus.flush_count, exp_stall, exp_flush);
        end
    endtask

    task automatic test_mem_wait();
        // Single-cycle access: no hold
        clear_inputs(); bus.exmem_memwrite = 1'b1; bus.mem_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (ctl() !== C_IDLE) begin fails++; $display("FAIL single_acc_ctl got=%b exp=%b", ctl(), C_IDLE); end
        @(posedge clk); #1;
        // Three hold cycles with a load-use pending throughout
        clear_inputs(); bus.exmem_memread = 1'b1; set_lu(5'd5, 5'd5, 5'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (ctl() !== C_HOLD) begin fails++; $display("FAIL wait_hold[%0d] got=%b exp=%b", i, ctl(), C_HOLD); end
            @(posedge clk); #1;
        end
        tests++;
        if (bus.stall_count !== exp_stall) begin fails++; $display("FAIL wait_nocount got=%0d exp=%0d", bus.stall_count, exp_stall); end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (ctl() !== C_STALL) begin fails++; $display("FAIL wait_release got=%b exp=%b", ctl(), C_STALL); end
        @(posedge clk); #1;
        exp_stall++;
        clear_inputs();
        @(negedge clk);
        tests++;
        if (ctl() !== C_IDLE) begin fails++; $display("FAIL wait_after got=%b exp=%b", ctl(), C_IDLE); end
        tests++;
        if ({bus.stall_count, bus.mem_error} !== {exp_stall, 1'b0}) begin
            fails++; $display("FAIL wait_bubble got st=%0d err=%b exp st=%0d err=0", bus.stall_count, bus.mem_error, exp_stall);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        clear_inputs(); bus.exmem_memread = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (ctl() !== C_HOLD) begin fails++; $display("FAIL to_hold[%0d] got=%b exp=%b", i, ctl(), C_HOLD); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        tests++;
        if ({ctl(), bus.mem_error} !== {C_IDLE, 1'b0}) begin
            fails++; $display("FAIL to_release got=%b err=%b exp=%b err=0", ctl(), bus.mem_error, C_IDLE);
        end
        @(posedge clk); #1;
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (bus.mem_error !== 1'b1) begin fails++; $display("FAIL to_sticky[%0d] got=%b exp=1", i, bus.mem_error); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_wait();
        clear_inputs(); bus.exmem_memread = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (ctl() !== C_HOLD) begin fails++; $display("FAIL rmw_pre got=%b exp=%b", ctl(), C_HOLD); end
        reset = 1'b1;
        #1;
        tests++;
        if (ctl() !== C_IDLE) begin fails++; $display("FAIL rmw_ctl got=%b exp=%b", ctl(), C_IDLE); end
        tests++;
        if ({bus.mem_error, bus.stall_count, bus.flush_count} !== 33'd0) begin
            fails++; $display("FAIL rmw_regs got err=%b st=%0d fl=%0d exp 0/0/0",
                              bus.mem_error, bus.stall_count, bus.flush_count);
        end
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (ctl() !== C_IDLE) begin fails++; $display("FAIL rmw_after got=%b exp=%b", ctl(), C_IDLE); end
    endtask

    initial begin
        tests = 0; fails = 0;
        exp_stall = 16'd0; exp_flush = 16'd0;
        test_reset();
        test_load_use();
        test_branches();
        test_priority();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
